nec_tx_scheduler: RTL and testbench



---
 rtl/nec_tx_scheduler.sv | 159 +++++++++++++++
 tb/tb_nec_tx_scheduler.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nec_tx_scheduler.sv
// nec_tx_scheduler: shares one NEC IR transmitter between NUM_REQ requesters.
// Picks one pending {addr, code} command, presents it to the transmitter with a
// one-cycle send pulse, then holds off for FRAME_CYCLES because the transmitter
// reports neither busy nor done. The holdoff also runs after reset, so a frame
// that was in flight when reset hit can finish.
// Optional build macro NEC_TXSCHED_FIXED_PRIO_EN: lowest-index request always
// wins and no round-robin pointer is kept. Default build is round-robin.
module nec_tx_scheduler #(
    parameter int NUM_REQ      = 2,
    parameter int FRAME_CYCLES = 13_500_000,
    parameter int CNT_W        = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_addr,
    input  logic [8*NUM_REQ-1:0] req_code,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [7:0]           tx_addr,
    output logic [7:0]           tx_code,
    output logic                 tx_send,
    output logic                 busy,
    output logic [1:0]           active_id
);

    // The grant itself is issued by the IDLE decision, so no separate grant
    // state ever holds for a cycle.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [7:0]           tx_addr_q, tx_addr_d;
    logic [7:0]           tx_code_q, tx_code_d;
    logic                 tx_send_q, tx_send_d;
    logic                 busy_q, busy_d;
    logic [1:0]           active_id_q, active_id_d;

    logic                 win_vld;
    int                   win_idx;

`ifdef NEC_TXSCHED_FIXED_PRIO_EN
    // Fixed priority: scan from the top down so the lowest set index is kept.
    always_comb begin
        win_vld = 1'b0;
        win_idx = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if ((req & (NUM_REQ'(1) << i)) != '0) begin
                win_vld = 1'b1;
                win_idx = i;
            end
        end
    end
`else
    logic [1:0] rr_ptr_q, rr_ptr_d;
    int         rr_idx;

    // Round-robin: search starts just after the last winner and wraps.
    always_comb begin
        win_vld = 1'b0;
        win_idx = 0;
        rr_idx  = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            rr_idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!win_vld && ((req >> rr_idx) & NUM_REQ'(1)) != '0) begin
                win_vld = 1'b1;
                win_idx = rr_idx;
            end
        end
    end
`endif

    // Next-state and registered-output decode for IDLE -> LAUNCH -> WAIT.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gnt_d       = '0;
        tx_addr_d   = tx_addr_q;
        tx_code_d   = tx_code_q;
        tx_send_d   = 1'b0;
        active_id_d = active_id_q;
`ifndef NEC_TXSCHED_FIXED_PRIO_EN
        rr_ptr_d    = rr_ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    gnt_d       = NUM_REQ'(1) << win_idx;
                    tx_addr_d   = 8'(req_addr >> (8 * win_idx));
                    tx_code_d   = 8'(req_code >> (8 * win_idx));
                    active_id_d = 2'(win_idx);
`ifndef NEC_TXSCHED_FIXED_PRIO_EN
                    rr_ptr_d    = 2'(win_idx);
`endif
                    state_d     = LAUNCH;
                end
            end
            LAUNCH: begin
                tx_send_d = 1'b1;
                cnt_d     = '0;
                state_d   = WAIT;
            end
            WAIT: begin
                // Terminal compare is the counter's only exit; it never wraps.
                if (cnt_q == CNT_W'(FRAME_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset restarts the full holdoff.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WAIT;
            cnt_q       <= '0;
            gnt_q       <= '0;
            tx_addr_q   <= '0;
            tx_code_q   <= '0;
            tx_send_q   <= 1'b0;
            busy_q      <= 1'b1;
            active_id_q <= '0;
`ifndef NEC_TXSCHED_FIXED_PRIO_EN
            rr_ptr_q    <= 2'(NUM_REQ - 1);
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            tx_addr_q   <= tx_addr_d;
            tx_code_q   <= tx_code_d;
            tx_send_q   <= tx_send_d;
            busy_q      <= busy_d;
            active_id_q <= active_id_d;
`ifndef NEC_TXSCHED_FIXED_PRIO_EN
            rr_ptr_q    <= rr_ptr_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign tx_addr   = tx_addr_q;
    assign tx_code   = tx_code_q;
    assign tx_send   = tx_send_q;
    assign busy      = busy_q;
    assign active_id = active_id_q;

endmodule

// File: tb/tb_nec_tx_scheduler.sv
// Bench for nec_tx_scheduler with FRAME_CYCLES=100, NUM_REQ=2.
// Reference model works at the transaction level: a grant is possible at an
// edge once the previous frame's spacing has elapsed, the send follows the
// grant by one edge, and the winner is chosen by the arbitration rule.
module tb_nec_tx_scheduler;
    localparam int NR = 2;
    localparam int FC = 100;
    localparam int AW = 8 * NR;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NR-1:0] req = '0;
    logic [AW-1:0] req_addr = '0;
    logic [AW-1:0] req_code = '0;
    logic [NR-1:0] gnt;
    logic [7:0]    tx_addr, tx_code;
    logic          tx_send, busy;
    logic [1:0]    active_id;

    always #5 clk = ~clk;

    nec_tx_scheduler #(.NUM_REQ(NR), .FRAME_CYCLES(FC), .CNT_W(24)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr),
        .req_code(req_code), .gnt(gnt), .tx_addr(tx_addr), .tx_code(tx_code),
        .tx_send(tx_send), .busy(busy), .active_id(active_id)
    );

    int checks = 0;
    int errors = 0;

    // model state
    int            e, next_ok, gnt_edge, last;
    logic [NR-1:0] exp_gnt;
    logic [7:0]    exp_addr, exp_code;
    logic          exp_send, exp_busy;
    logic [1:0]    exp_id;
    logic          prev_send, prev_busy;
    logic [7:0]    prev_addr, prev_code;

    task automatic model_reset();
        e = 0; next_ok = FC + 1; gnt_edge = -1000; last = NR - 1;
        exp_gnt = '0; exp_addr = '0; exp_code = '0; exp_send = 1'b0;
        exp_busy = 1'b1; exp_id = '0;
        prev_send = 1'b0; prev_busy = 1'b1; prev_addr = '0; prev_code = '0;
    endtask

    function automatic int pick(logic [NR-1:0] r);
`ifdef NEC_TXSCHED_FIXED_PRIO_EN
        for (int i = 0; i < NR; i++) if (((r >> i) & NR'(1)) != '0) return i;
`else
        for (int k = 1; k <= NR; k++) begin
            int i;
            i = (last + k) % NR;
            if (((r >> i) & NR'(1)) != '0) return i;
        end
`endif
        return 0;
    endfunction

    task automatic set_req(int i, logic v, logic [7:0] a, logic [7:0] c);
        req      = (req & ~(NR'(1) << i)) | (NR'(v) << i);
        req_addr = (req_addr & ~(AW'(8'hFF) << (8 * i))) | (AW'(a) << (8 * i));
        req_code = (req_code & ~(AW'(8'hFF) << (8 * i))) | (AW'(c) << (8 * i));
    endtask

    // Advance one edge, update the model, compare every output and invariant.
    task automatic step();
        logic [NR-1:0] r;
        logic [AW-1:0] a, c;
        int            w;
        r = req; a = req_addr; c = req_code;
        @(posedge clk);
        e++;
        exp_send = (e == gnt_edge + 1);
        exp_gnt  = '0;
        if (e >= next_ok && r != '0) begin
            w        = pick(r);
            exp_gnt  = NR'(1) << w;
            exp_addr = 8'(a >> (8 * w));
            exp_code = 8'(c >> (8 * w));
            exp_id   = 2'(w);
            last     = w;
            gnt_edge = e;
            next_ok  = e + FC + 2;
        end
        exp_busy = (e < next_ok - 1);
        #1;
        checks++; if (gnt !== exp_gnt) begin errors++; $display("FAIL gnt e=%0d got %b want %b", e, gnt, exp_gnt); end
        checks++; if (tx_send !== exp_send) begin errors++; $display("FAIL tx_send e=%0d got %b want %b", e, tx_send, exp_send); end
        checks++; if (tx_addr !== exp_addr) begin errors++; $display("FAIL tx_addr e=%0d got %h want %h", e, tx_addr, exp_addr); end
        checks++; if (tx_code !== exp_code) begin errors++; $display("FAIL tx_code e=%0d got %h want %h", e, tx_code, exp_code); end
        checks++; if (active_id !== exp_id) begin errors++; $display("FAIL active_id e=%0d got %0d want %0d", e, active_id, exp_id); end
        checks++; if (busy !== exp_busy) begin errors++; $display("FAIL busy e=%0d got %b want %b", e, busy, exp_busy); end
        checks++; if (!$onehot0(gnt)) begin errors++; $display("FAIL gnt_onehot e=%0d got %b want onehot0", e, gnt); end
        checks++; if (tx_send && prev_send) begin errors++; $display("FAIL send_twice e=%0d got 11 want not 11", e); end
        checks++;
        if (busy && prev_busy && (tx_addr !== prev_addr || tx_code !== prev_code)) begin
            errors++; $display("FAIL tx_stable e=%0d got %h/%h want %h/%h", e, tx_addr, tx_code, prev_addr, prev_code);
        end
        prev_send = tx_send; prev_busy = busy; prev_addr = tx_addr; prev_code = tx_code;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3 * FC && busy !== 1'b0; i++) step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wait_idle got busy=%b want 0", busy); end
    endtask

    task automatic check_reset_vals(string tag);
        checks++;
        if (gnt !== '0 || tx_send !== 1'b0 || busy !== 1'b1 || tx_addr !== 8'h00 ||
            tx_code !== 8'h00 || active_id !== 2'd0) begin
            errors++;
            $display("FAIL %s got gnt=%b send=%b busy=%b addr=%h code=%h id=%0d want 0/0/1/00/00/0",
                     tag, gnt, tx_send, busy, tx_addr, tx_code, active_id);
        end
    endtask

    task automatic release_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        int first;
        #12;
        check_reset_vals("reset_values");
        set_req(0, 1'b1, 8'h5A, 8'hC7);
        release_reset();
        first = -1;
        for (int i = 0; i < FC + 2; i++) begin
            step();
            if (gnt[0] === 1'b1 && first < 0) first = e;
        end
        checks++; if (first != FC + 1) begin errors++; $display("FAIL holdoff_first_gnt got %0d want %0d", first, FC + 1); end
        checks++;
        if (tx_send !== 1'b1 || tx_addr !== 8'h5A || tx_code !== 8'hC7) begin
            errors++; $display("FAIL first_launch got send=%b %h/%h want 1 5a/c7", tx_send, tx_addr, tx_code);
        end
        req = '0;
    endtask

    task automatic test_single();
        int g, e0, bcnt;
        wait_idle();
        e0 = e;
        set_req(0, 1'b1, 8'h00, 8'h45);
        g = -1; bcnt = 0;
        for (int i = 0; i < 5 && g < 0; i++) begin
            step();
            if (gnt === 2'b01) g = e;
        end
        checks++; if (g != e0 + 1) begin errors++; $display("FAIL single_gnt_edge got %0d want %0d", g, e0 + 1); end
        req = '0;
        if (busy === 1'b1) bcnt++;
        step();
        if (busy === 1'b1) bcnt++;
        checks++;
        if (tx_send !== 1'b1 || tx_addr !== 8'h00 || tx_code !== 8'h45) begin
            errors++; $display("FAIL single_launch got send=%b %h/%h want 1 00/45", tx_send, tx_addr, tx_code);
        end
        for (int i = 0; i < 3 * FC; i++) begin
            step();
            if (busy !== 1'b1) break;
            bcnt++;
        end
        // Busy spans LAUNCH plus FC cycles of WAIT; IDLE is the (FC+2)th cycle.
        checks++; if (bcnt != FC + 1) begin errors++; $display("FAIL busy_len got %0d want %0d", bcnt, FC + 1); end
    endtask

    task automatic test_back_to_back();
        logic [NR-1:0] gseq[$];
        int            sends[$];
        wait_idle();
        set_req(0, 1'b1, 8'h11, 8'hA1);
        set_req(1, 1'b1, 8'h22, 8'hB2);
        for (int i = 0; i < 4 * (FC + 2) + 4 && sends.size() < 4; i++) begin
            step();
            if (gnt !== '0) gseq.push_back(gnt);
            if (tx_send === 1'b1) sends.push_back(e);
        end
        checks++; if (sends.size() != 4) begin errors++; $display("FAIL b2b_sends got %0d want 4", sends.size()); end
        for (int k = 1; k < sends.size(); k++) begin
            checks++;
            if (sends[k] - sends[k-1] != FC + 2) begin
                errors++; $display("FAIL b2b_spacing got %0d want %0d", sends[k] - sends[k-1], FC + 2);
            end
        end
        for (int k = 0; k < gseq.size(); k++) begin
            checks++;
`ifdef NEC_TXSCHED_FIXED_PRIO_EN
            if (gseq[k] !== 2'b01) begin errors++; $display("FAIL b2b_fixed got %b want 01", gseq[k]); end
`else
            if (k > 0 && gseq[k] === gseq[k-1]) begin
                errors++; $display("FAIL b2b_alternate got %b want not %b", gseq[k], gseq[k-1]);
            end
`endif
        end
        req = '0;
    endtask

    task automatic test_wait_glitch();
        int g1, ns;
        wait_idle();
        set_req(0, 1'b1, 8'h3C, 8'hC3);
        for (int i = 0; i < 5 && gnt !== 2'b01; i++) step();
        req = '0;
        g1 = 0; ns = 0;
        for (int i = 0; i < FC + 8; i++) begin
            if (i == 10) set_req(1, 1'b1, 8'h99, 8'h66);
            if (i == 30) req = '0;
            step();
            if (gnt[1] === 1'b1) g1++;
            if (tx_send === 1'b1) ns++;
        end
        checks++; if (g1 != 0) begin errors++; $display("FAIL glitch_gnt1 got %0d want 0", g1); end
        checks++; if (ns != 1) begin errors++; $display("FAIL glitch_sends got %0d want 1", ns); end
        checks++;
        if (tx_addr !== 8'h3C || tx_code !== 8'hC3) begin
            errors++; $display("FAIL glitch_tx got %h/%h want 3c/c3", tx_addr, tx_code);
        end
    endtask

    task automatic test_reset_mid_frame();
        int first;
        // reset while tx_send is high
        wait_idle();
        set_req(0, 1'b1, 8'h81, 8'h18);
        for (int i = 0; i < 5 && gnt !== 2'b01; i++) step();
        step();
        #1 rst_n = 1'b0;
        model_reset();
        #1 check_reset_vals("reset_during_send");
        release_reset();
        for (int i = 0; i < FC + 2; i++) step();
        // reset 30 cycles into WAIT
        for (int i = 0; i < 30; i++) step();
        #1 rst_n = 1'b0;
        model_reset();
        #1 check_reset_vals("reset_in_wait");
        release_reset();
        first = -1;
        for (int i = 0; i < FC + 4; i++) begin
            step();
            if (gnt !== '0 && first < 0) first = e;
        end
        checks++; if (first < FC) begin errors++; $display("FAIL post_reset_holdoff got %0d want >=%0d", first, FC); end
        req = '0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 4000; n++) begin
            step();
            for (int i = 0; i < NR; i++) begin
                if (((req >> i) & NR'(1)) != '0) begin
                    if (((gnt >> i) & NR'(1)) != '0) begin
                        if ($urandom_range(3) != 0) set_req(i, 1'b0, 8'(req_addr >> (8 * i)), 8'(req_code >> (8 * i)));
                    end else if ($urandom_range(99) == 0) begin
                        set_req(i, 1'b0, 8'(req_addr >> (8 * i)), 8'(req_code >> (8 * i)));
                    end
                end else if ($urandom_range(19) == 0) begin
                    set_req(i, 1'b1, 8'($urandom), 8'($urandom));
                end
            end
        end
        req = '0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_back_to_back();
        test_wait_glitch();
        test_reset_mid_frame();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
